// File: rtl/invader_march_ctrl.sv
// Purpose : steps the invader formation anchor left/right, descends one row at each edge, flags landing.
// Latency : position/Dir update on the edge that samples a step event; Moved is high the following cycle.
// Backpress: none; Tick is a one-cycle strobe, and Run=0 holds the divider, position and state.
//
// Ports:
//   CLK     system clock
//   Rst     synchronous active-high reset (priority over everything)
//   Tick    movement strobe from the upstream tick counter
//   Run     1 = march enabled, 0 = hold
//   Speed   step divider: one step per Speed+1 qualified ticks
//   FormX   formation anchor X
//   FormY   formation anchor Y
//   Dir     1 = moving right, 0 = moving left (0 once landed)
//   Moved   one-cycle pulse while the freshly updated position is visible
//   Landed  sticky landing flag, cleared only by Rst
module invader_march_ctrl #(
  parameter logic [9:0] X_MIN   = 10'd16,
  parameter logic [9:0] X_MAX   = 10'd400,
  parameter logic [9:0] X_START = 10'd200,
  parameter logic [9:0] Y_START = 10'd40,
  parameter logic [9:0] Y_LAND  = 10'd424,
  parameter logic [9:0] STEP_X  = 10'd8,
  parameter logic [9:0] STEP_Y  = 10'd16
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Run,
  input  logic [2:0] Speed,
  output logic [9:0] FormX,
  output logic [9:0] FormY,
  output logic       Dir,
  output logic       Moved,
  output logic       Landed
);

  typedef enum logic [1:0] {
    MARCH_R = 2'd0,
    MARCH_L = 2'd1,
    LANDED  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [9:0] form_x_nxt, form_y_nxt;
  logic       landed_nxt;
  logic       step;
  logic       descend;

  logic       qual;
  // Edge compares are done one bit wider so a sum near the top of the
  // 10-bit range cannot wrap and look like an in-bounds position.
  logic [10:0] x_right;
  logic [10:0] x_left_lim;
  logic [10:0] y_down;

  assign qual       = Tick & Run & (state != LANDED);
  assign x_right    = {1'b0, FormX} + {1'b0, STEP_X};
  assign x_left_lim = {1'b0, X_MIN} + {1'b0, STEP_X};
  assign y_down     = {1'b0, FormY} + {1'b0, STEP_Y};
  assign Dir        = (state == MARCH_R);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    form_x_nxt = FormX;
    form_y_nxt = FormY;
    landed_nxt = Landed;
    step       = 1'b0;
    descend    = 1'b0;

    // >= rather than == so lowering Speed mid-count steps immediately
    // instead of running the counter all the way around.
    if (qual) begin
      if (cnt >= Speed) begin
        cnt_nxt = 3'd0;
        step    = 1'b1;
      end else begin
        cnt_nxt = cnt + 3'd1;
      end
    end

    if (step) begin
      case (state)
        MARCH_R: begin
          if (x_right > {1'b0, X_MAX}) descend = 1'b1;
          else                         form_x_nxt = x_right[9:0];
        end
        MARCH_L: begin
          if ({1'b0, FormX} < x_left_lim) descend = 1'b1;
          else                            form_x_nxt = FormX - STEP_X;
        end
        default: ;
      endcase
    end

    // X stays put on a descent; the reversal is the whole move.
    if (descend) begin
      if (y_down >= {1'b0, Y_LAND}) begin
        form_y_nxt = Y_LAND;
        landed_nxt = 1'b1;
        state_nxt  = LANDED;
      end else begin
        form_y_nxt = y_down[9:0];
        state_nxt  = (state == MARCH_R) ? MARCH_L : MARCH_R;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state  <= MARCH_R;
      cnt    <= 3'd0;
      FormX  <= X_START;
      FormY  <= Y_START;
      Moved  <= 1'b0;
      Landed <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      FormX  <= form_x_nxt;
      FormY  <= form_y_nxt;
      Moved  <= step;
      Landed <= landed_nxt;
    end
  end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Purpose : self-checking bench for invader_march_ctrl (vector table, scoreboard, edge/landing sequences).
// Latency : checks position on the edge after each drive, Moved during the following cycle.
// Backpress: n/a; stimulus is one Tick pulse followed by an idle cycle.
module tb_invader_march_ctrl;

  logic       CLK;
  logic       Rst;
  logic       Tick;
  logic       Run;
  logic [2:0] Speed;
  logic [9:0] FormX;
  logic [9:0] FormY;
  logic       Dir;
  logic       Moved;
  logic       Landed;

  invader_march_ctrl dut (
    .CLK   (CLK),
    .Rst   (Rst),
    .Tick  (Tick),
    .Run   (Run),
    .Speed (Speed),
    .FormX (FormX),
    .FormY (FormY),
    .Dir   (Dir),
    .Moved (Moved),
    .Landed(Landed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected post-step state, queued when the stimulus causing it is driven.
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    bit         dir;
    bit         land;
  } exp_t;

  exp_t sb[$];

  // Behavioural reference model.
  int mx, my, mcnt;
  bit mdir, mland;

  task automatic model(input bit rst, input bit tk, input bit rn, input int sp);
    exp_t e;
    if (rst) begin
      mx = 200; my = 40; mdir = 1'b1; mcnt = 0; mland = 1'b0;
      return;
    end
    if (!(tk && rn && !mland)) return;
    if (mcnt < sp) begin
      mcnt++;
      return;
    end
    mcnt = 0;
    if (mdir && (mx + 8 <= 400))       mx = mx + 8;
    else if (!mdir && (mx >= 16 + 8))  mx = mx - 8;
    else if (my + 16 >= 424) begin
      my = 424; mland = 1'b1; mdir = 1'b0;
    end else begin
      my = my + 16; mdir = !mdir;
    end
    e.x = 10'(mx); e.y = 10'(my); e.dir = mdir; e.land = mland;
    sb.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit tk, input bit rn, input logic [2:0] sp);
    Rst = rst; Tick = tk; Run = rn; Speed = sp;
    model(rst, tk, rn, int'(sp));
    @(posedge CLK);
    #1;
    Rst = 1'b0; Tick = 1'b0;
  endtask

  task automatic tick_gap(input logic [2:0] sp);
    drive(1'b0, 1'b1, 1'b1, sp);
    drive(1'b0, 1'b0, 1'b1, sp);
  endtask

  // Scoreboard: every Moved pulse must match the oldest queued expectation.
  bit   mon_en = 1'b0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (mon_en && Moved === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_moved", 32'(Moved), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_x",      32'(FormX),  32'(mon_e.x));
        chk("sb_y",      32'(FormY),  32'(mon_e.y));
        chk("sb_dir",    32'(Dir),    32'(mon_e.dir));
        chk("sb_landed", 32'(Landed), 32'(mon_e.land));
      end
    end
  end

  typedef struct {
    bit         rst;
    bit         tick;
    bit         run;
    logic [2:0] spd;
    logic [9:0] x;
    logic [9:0] y;
    bit         dir;
    bit         moved;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit t, input bit n, input int s,
                     input int x, input int y, input bit d, input bit m);
    vec_t v;
    v.rst = r; v.tick = t; v.run = n; v.spd = 3'(s);
    v.x = 10'(x); v.y = 10'(y); v.dir = d; v.moved = m;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   saved_y;
    vec_t v;
    Rst = 1'b1; Tick = 1'b0; Run = 1'b0; Speed = 3'd0;
    mx = 0; my = 0; mcnt = 0; mdir = 1'b0; mland = 1'b0;

    // Reset state.
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    chk("rst_x",      32'(FormX),  32'd200);
    chk("rst_y",      32'(FormY),  32'd40);
    chk("rst_dir",    32'(Dir),    32'd1);
    chk("rst_moved",  32'(Moved),  32'd0);
    chk("rst_landed", 32'(Landed), 32'd0);
    mon_en = 1'b1;

    //  rst tick run spd   x    y  dir moved
    add(0, 1, 1, 0, 208, 40, 1, 1);   // Speed 0: step on first tick
    add(1, 0, 1, 0, 200, 40, 1, 0);
    add(0, 1, 1, 3, 200, 40, 1, 0);   // Speed 3: four ticks per step
    add(0, 1, 1, 3, 200, 40, 1, 0);
    add(0, 1, 1, 3, 200, 40, 1, 0);
    add(0, 1, 1, 3, 208, 40, 1, 1);
    add(0, 1, 1, 3, 208, 40, 1, 0);
    add(0, 1, 1, 3, 208, 40, 1, 0);
    add(0, 1, 1, 3, 208, 40, 1, 0);
    add(0, 1, 1, 3, 216, 40, 1, 1);   // 8 ticks -> 216
    add(0, 1, 1, 3, 216, 40, 1, 0);   // count 1
    add(0, 1, 1, 3, 216, 40, 1, 0);   // count 2
    add(0, 1, 0, 3, 216, 40, 1, 0);   // Run=0: ticks ignored
    add(0, 1, 0, 3, 216, 40, 1, 0);
    add(0, 1, 0, 3, 216, 40, 1, 0);
    add(0, 1, 0, 3, 216, 40, 1, 0);
    add(0, 1, 0, 3, 216, 40, 1, 0);
    add(0, 1, 1, 3, 216, 40, 1, 0);   // count 3: resumed, not restarted
    add(0, 1, 1, 3, 224, 40, 1, 1);
    add(1, 1, 1, 0, 200, 40, 1, 0);   // Rst wins over a step-qualifying tick

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.rst, v.tick, v.run, v.spd);
      chk($sformatf("vec%0d_x", i),     32'(FormX), 32'(v.x));
      chk($sformatf("vec%0d_y", i),     32'(FormY), 32'(v.y));
      chk($sformatf("vec%0d_dir", i),   32'(Dir),   32'(v.dir));
      chk($sformatf("vec%0d_moved", i), 32'(Moved), 32'(v.moved));
      drive(1'b0, 1'b0, v.run, v.spd);
      chk($sformatf("vec%0d_moved_gap", i), 32'(Moved), 32'd0);
    end

    // Right edge.
    drive(1'b1, 1'b0, 1'b1, 3'd0);
    repeat (25) tick_gap(3'd0);
    chk("redge_x25", 32'(FormX), 32'd400);
    tick_gap(3'd0);
    chk("redge_x26",   32'(FormX), 32'd400);
    chk("redge_y26",   32'(FormY), 32'd56);
    chk("redge_dir26", 32'(Dir),   32'd0);
    tick_gap(3'd0);
    chk("redge_x27", 32'(FormX), 32'd392);

    // Left edge.
    repeat (47) tick_gap(3'd0);
    chk("ledge_x",   32'(FormX), 32'd16);
    chk("ledge_dir", 32'(Dir),   32'd0);
    tick_gap(3'd0);
    chk("ledge_x_rev",   32'(FormX), 32'd16);
    chk("ledge_y_rev",   32'(FormY), 32'd72);
    chk("ledge_dir_rev", 32'(Dir),   32'd1);
    tick_gap(3'd0);
    chk("ledge_x_next", 32'(FormX), 32'd24);

    // Landing.
    for (int i = 0; i < 3000 && FormY != 10'd408; i++) tick_gap(3'd0);
    chk("land_pre_y", 32'(FormY), 32'd408);
    for (int i = 0; i < 200 && Landed !== 1'b1; i++) tick_gap(3'd0);
    chk("land_y",      32'(FormY),  32'd424);
    chk("land_flag",   32'(Landed), 32'd1);
    chk("land_dir",    32'(Dir),    32'd0);
    saved_y = 424;
    repeat (5) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0);
      chk("landed_moved", 32'(Moved),  32'd0);
      chk("landed_x",     32'(FormX),  32'(mx));
      chk("landed_y",     32'(FormY),  32'(saved_y));
      chk("landed_flag",  32'(Landed), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 3'd0);
    end
    drive(1'b1, 1'b0, 1'b1, 3'd0);
    chk("post_rst_x",      32'(FormX),  32'd200);
    chk("post_rst_y",      32'(FormY),  32'd40);
    chk("post_rst_dir",    32'(Dir),    32'd1);
    chk("post_rst_moved",  32'(Moved),  32'd0);
    chk("post_rst_landed", 32'(Landed), 32'd0);
    tick_gap(3'd0);
    chk("post_rst_step", 32'(FormX), 32'd208);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/invader_march_ctrl.md
Name: invader_march_ctrl

Overview:
- Consumes the one-cycle movement strobe M from the upstream tick-counter stage on input Tick.
- Steps the alien formation's anchor position horizontally and reverses direction at the playfield edges, descending one row on each reversal.
- Flags a landing when the formation reaches the player row.
- Downstream, the sprite renderer and collision logic read FormX/FormY; the game FSM reads Landed.

Parameters:
- X_MIN, 10'd16, leftmost legal formation X.
- X_MAX, 10'd400, rightmost legal formation X.
- X_START, 10'd200, formation X after reset.
- Y_START, 10'd40, formation Y after reset.
- Y_LAND, 10'd424, Y at which the invaders have landed.
- STEP_X, 10'd8, horizontal pixels per step.
- STEP_Y, 10'd16, vertical pixels per descent.

Ports:
- CLK  in  1  system clock.
- Rst  in  1  synchronous active-high reset.
- Tick  in  1  movement strobe from upstream counter, one cycle wide.
- Run  in  1  1 = march enabled; 0 = hold everything.
- Speed  in  3  step divider: one step per Speed+1 qualified ticks.
- FormX  out  10  formation anchor X.
- FormY  out  10  formation anchor Y.
- Dir  out  1  1 = moving right, 0 = moving left.
- Moved  out  1  one-cycle pulse after each position update.
- Landed  out  1  sticky landing flag.

Behaviour:
- One clock, CLK; reset is synchronous and active-high on Rst. Rst has priority over all other inputs.
- Reset values:
  - FormX=X_START, FormY=Y_START.
  - State MARCH_R, so Dir=1.
  - Moved=0, Landed=0, divider count=0.
- States:
  - MARCH_R and MARCH_L. Dir is 1 in MARCH_R and 0 otherwise.
  - LANDED: all outputs frozen and Moved=0 until Rst. Ticks are ignored.
- Qualified tick: Tick & Run & state!=LANDED. Run=0 freezes the divider, position and state; no side effects.
- Divider: a 3-bit count, evaluated only on a qualified tick.
  - If count>=Speed: count<=0 and a step event occurs.
  - Otherwise: count<=count+1.
  - The >= comparison covers Speed being lowered mid-count. Speed=0 gives a step on every qualified tick.
- Step event in MARCH_R:
  - If FormX+STEP_X > X_MAX (11-bit compare, no wrap): descend and go to MARCH_L.
  - Otherwise FormX<=FormX+STEP_X.
- Step event in MARCH_L:
  - If FormX < X_MIN+STEP_X: descend and go to MARCH_R.
  - Otherwise FormX<=FormX-STEP_X.
- Descend:
  - FormX is unchanged.
  - If FormY+STEP_Y >= Y_LAND: FormY<=Y_LAND, Landed<=1, go to LANDED.
  - Otherwise FormY<=FormY+STEP_Y.
- Latency and timing:
  - A step event sampled at edge N updates FormX/FormY/Dir at edge N.
  - Moved is registered and is high during cycle N+1 only, so it coincides with the new values being visible.
- Moved never stays high two consecutive cycles. Two step events are at least two cycles apart because Tick is a pulse.
- All arithmetic is 10-bit unsigned. Boundary compares use 11-bit sums so there is no overflow aliasing.
- Rst on the same edge as a step event: reset values win and Moved=0 next cycle.
- Landed is sticky; only Rst clears it.

Test Plan:
- Reset, Run=1, Speed=0, one Tick: FormX 200->208, Dir=1, Moved high exactly one cycle after the Tick edge.
- Speed=3, Run=1, 8 Ticks: FormX=216 (2 steps). Drop Run=0 mid-count and pulse 5 Ticks: no change. Raise Run=1: the count resumes where it stopped.
- Speed=0, 25 Ticks: FormX=400. 26th Tick: FormX=400, FormY=56, Dir=0. 27th Tick: FormX=392.
- Left edge: march to FormX=16, next Tick: FormY +16, Dir=1, FormX=16. Next Tick: FormX=24.
- Force repeated edge hits until FormY=408, then trigger a descent: FormY=424, Landed=1. Further Ticks: no change and Moved=0. Rst: all reset values restored.
- Rst asserted on the same cycle as a qualifying Tick: FormX=200, FormY=40, Moved=0 next cycle.
